// File: rtl/patch_dispatcher.sv
// Patch dispatcher: binds incoming pixels to hardware threads, queues the threads and
// dispatches them to idle ray-tracing cores; pulses patch_done_o once a patch has retired.
module patch_dispatcher #(
    parameter int unsigned NUM_RT      = 4,
    parameter int unsigned NUM_THREAD  = 32,
    parameter logic [31:0] START_PC    = 32'h0,
    parameter logic [31:0] STACK_BASE  = 32'h0,
    parameter logic [31:0] STACK_BYTES = 32'h400,
    localparam int unsigned BIT_THREAD = $clog2(NUM_THREAD)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic [31:0]                  pixel_id_i,
    input  logic                         last_i,
    output logic                         load_rdy_o,
    output logic [NUM_RT-1:0]            job_dispatch_o,
    output logic [BIT_THREAD-1:0]        thread_id_o,
    output logic [31:0]                  pixel_id_o,
    output logic [31:0]                  pc_o,
    output logic [31:0]                  sp_o,
    input  logic [NUM_RT-1:0]            task_done_i,
    input  logic [NUM_RT-1:0]            context_switch_i,
    input  logic [NUM_RT*BIT_THREAD-1:0] thread_id_i,
    input  logic [NUM_RT*32-1:0]         pc_i,
    input  logic [NUM_RT*32-1:0]         sp_i,
    output logic [NUM_RT-1:0]            rpt_ack_o,
    output logic                         patch_done_o,
    output logic                         err_o
);
    localparam int unsigned CoreW = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [1:0] {ThFree, ThQueued, ThRunning} thread_e;

    state_e                state_q, state_d;
    thread_e               th_state_q [NUM_THREAD];
    logic [31:0]           th_pix_q   [NUM_THREAD];
    logic [31:0]           th_pc_q    [NUM_THREAD];
    logic [31:0]           th_sp_q    [NUM_THREAD];
    logic [BIT_THREAD-1:0] fifo_q     [NUM_THREAD];
    logic [BIT_THREAD-1:0] head_q, tail_q;
    logic [BIT_THREAD:0]   count_q;
    logic [NUM_RT-1:0]     core_busy_q;
    logic [BIT_THREAD-1:0] core_tid_q [NUM_RT];
    logic                  last_seen_q;
    logic [NUM_RT-1:0]     job_dispatch_q;
    logic [BIT_THREAD-1:0] thread_id_q;
    logic [31:0]           pixel_id_q, pc_q, sp_q;
    logic                  patch_done_q, err_q;

    logic                  free_found, all_free, idle_found, rpt_found;
    logic [BIT_THREAD-1:0] free_tid, rpt_tid, push_tid, disp_tid;
    logic [CoreW-1:0]      idle_core, rpt_core;
    logic [BIT_THREAD-1:0] rep_tid [NUM_RT];
    logic [31:0]           rep_pc  [NUM_RT];
    logic [31:0]           rep_sp  [NUM_RT];
    logic                  rpt_is_cs, rpt_valid, cs_push, load_acc, disp, drain, push;
    logic [31:0]           new_sp;

    function automatic logic [BIT_THREAD-1:0] ptr_inc(input logic [BIT_THREAD-1:0] p);
        return (p == BIT_THREAD'(NUM_THREAD - 1)) ? '0 : p + 1'b1;
    endfunction

    // Priority picks: lowest free thread, lowest idle core, lowest reporting core.
    always_comb begin
        free_found = 1'b0;
        free_tid   = '0;
        all_free   = 1'b1;
        for (int t = 0; t < int'(NUM_THREAD); t++) begin
            if (th_state_q[t] == ThFree) begin
                if (!free_found) free_tid = BIT_THREAD'(t);
                free_found = 1'b1;
            end else begin
                all_free = 1'b0;
            end
        end
        idle_found = 1'b0;
        idle_core  = '0;
        rpt_found  = 1'b0;
        rpt_core   = '0;
        for (int c = 0; c < int'(NUM_RT); c++) begin
            rep_tid[c] = thread_id_i[c*BIT_THREAD +: BIT_THREAD];
            rep_pc[c]  = pc_i[c*32 +: 32];
            rep_sp[c]  = sp_i[c*32 +: 32];
            if (!core_busy_q[c] && !idle_found) begin
                idle_found = 1'b1;
                idle_core  = CoreW'(c);
            end
            if ((task_done_i[c] || context_switch_i[c]) && !rpt_found && !rst_i) begin
                rpt_found = 1'b1;
                rpt_core  = CoreW'(c);
            end
        end
    end

    always_comb begin
        rpt_ack_o = '0;
        if (rpt_found) rpt_ack_o[rpt_core] = 1'b1;
        rpt_tid   = rep_tid[rpt_core];
        rpt_is_cs = rpt_found && !task_done_i[rpt_core];
        rpt_valid = core_busy_q[rpt_core] && (core_tid_q[rpt_core] == rpt_tid)
                    && (th_state_q[rpt_tid] == ThRunning);
        cs_push    = rpt_is_cs && rpt_valid;
        load_rdy_o = !rst_i && free_found && !last_seen_q && (state_q != StDone) && !rpt_is_cs;
        load_acc   = load_i && load_rdy_o;
        push       = load_acc || cs_push;
        push_tid   = load_acc ? free_tid : rpt_tid;
        disp       = (count_q != '0) && idle_found;
        disp_tid   = fifo_q[head_q];
        drain      = (state_q == StRun) && last_seen_q && all_free && (count_q == '0)
                     && (core_busy_q == '0);
        new_sp     = STACK_BASE + 32'(free_tid) * STACK_BYTES;
        state_d    = state_q;
        unique case (state_q)
            StIdle:  if (load_acc) state_d = StRun;
            StRun:   if (drain) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            core_busy_q    <= '0;
            last_seen_q    <= 1'b0;
            job_dispatch_q <= '0;
            thread_id_q    <= '0;
            pixel_id_q     <= '0;
            pc_q           <= '0;
            sp_q           <= '0;
            patch_done_q   <= 1'b0;
            err_q          <= 1'b0;
            for (int t = 0; t < int'(NUM_THREAD); t++) th_state_q[t] <= ThFree;
        end else begin
            state_q        <= state_d;
            patch_done_q   <= drain;
            job_dispatch_q <= '0;
            thread_id_q    <= '0;
            pixel_id_q     <= '0;
            pc_q           <= '0;
            sp_q           <= '0;
            if (drain) last_seen_q <= 1'b0;
            if (load_acc) begin
                th_state_q[free_tid] <= ThQueued;
                th_pix_q[free_tid]   <= pixel_id_i;
                th_pc_q[free_tid]    <= START_PC;
                th_sp_q[free_tid]    <= new_sp;
                if (last_i) last_seen_q <= 1'b1;
            end
            if (rpt_found) begin
                if (!rpt_valid) begin
                    err_q <= 1'b1;
                end else begin
                    core_busy_q[rpt_core] <= 1'b0;
                    th_state_q[rpt_tid]   <= rpt_is_cs ? ThQueued : ThFree;
                    if (rpt_is_cs) begin
                        th_pc_q[rpt_tid] <= rep_pc[rpt_core];
                        th_sp_q[rpt_tid] <= rep_sp[rpt_core];
                    end
                end
            end
            if (push) begin
                fifo_q[tail_q] <= push_tid;
                tail_q         <= ptr_inc(tail_q);
            end
            // Dispatch targets an idle core and a queued thread, so it never collides
            // with the report or load updates above.
            if (disp) begin
                head_q                    <= ptr_inc(head_q);
                th_state_q[disp_tid]      <= ThRunning;
                core_busy_q[idle_core]    <= 1'b1;
                core_tid_q[idle_core]     <= disp_tid;
                job_dispatch_q[idle_core] <= 1'b1;
                thread_id_q               <= disp_tid;
                pixel_id_q                <= th_pix_q[disp_tid];
                pc_q                      <= th_pc_q[disp_tid];
                sp_q                      <= th_sp_q[disp_tid];
            end
            if (push && !disp) count_q <= count_q + 1'b1;
            else if (!push && disp) count_q <= count_q - 1'b1;
        end
    end

    assign job_dispatch_o = job_dispatch_q;
    assign thread_id_o    = thread_id_q;
    assign pixel_id_o     = pixel_id_q;
    assign pc_o           = pc_q;
    assign sp_o           = sp_q;
    assign patch_done_o   = patch_done_q;
    assign err_o          = err_q;

endmodule
